truth_table_sweeper: RTL and testbench

- Sequential stimulus/checker stage wrapped around a 3-input combinational logic function module (e.g. the 0x28 gate).
- Upstream role: drives in1/in2/in3 through all 8 combinations, holding each one for a settle window.
- Downstream role: samples the function's single output after each window and assembles the measured 8-bit truth table.
- Compares the measured table against an expected hex code and reports match plus a per-row mismatch mask.

---
 rtl/truth_table_sweeper_pkg.sv | 19 +
 rtl/truth_table_sweeper_if.sv | 27 ++
 rtl/m0x28.sv | 11 +
 rtl/truth_table_sweeper_settle_timer.sv | 27 ++
 rtl/truth_table_sweeper.sv | 133 +++++++++++++
 tb/tb_truth_table_sweeper.sv | 240 ++++++++++++++++++++++++
 6 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and helpers for the truth-table sweeper: FSM states, row geometry,
// and the row-to-table-bit mapping (row 000 lands in the MSB).
package truth_table_pkg;

  localparam int unsigned ROWS  = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    FINISH
  } state_t;

  function automatic logic [IDX_W-1:0] row_to_bit(input logic [IDX_W-1:0] r);
    return IDX_W'(ROWS - 1) - r;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Control, stimulus and result signals between the sweeper and its environment.
interface truth_table_sweeper_if;
  import truth_table_pkg::*;

  logic            start;
  logic            abort;
  logic            dut_out;
  logic            in1;
  logic            in2;
  logic            in3;
  logic            busy;
  logic            done;
  logic [ROWS-1:0] table_out;
  logic            match;
  logic [ROWS-1:0] mismatch_mask;

  modport master (
    output start, abort, dut_out,
    input  in1, in2, in3, busy, done, table_out, match, mismatch_mask
  );

  modport slave (
    input  start, abort, dut_out,
    output in1, in2, in3, busy, done, table_out, match, mismatch_mask
  );

endinterface

// File: rtl/m0x28.sv
// Reference 3-input logic function 0x28: high only for rows 010 and 100.
module m0x28 (
  input  logic in1,
  input  logic in2,
  input  logic in3,
  output logic out_c
);

  assign out_c = (~in1 & in2 & ~in3) | (in1 & ~in2 & ~in3);

endmodule

// File: rtl/truth_table_sweeper_settle_timer.sv
// Settle-window counter: clears on request, counts up while enabled, flags the last cycle.
module settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc_c = (cnt == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks a 3-input function through all 8 rows, samples its output after a settle
// window per row, and compares the measured truth table with an expected code.
module truth_table_sweeper
  import truth_table_pkg::*;
#(
  parameter int unsigned     SETTLE_CYCLES = 4,
  parameter logic [ROWS-1:0] EXPECTED      = 8'h28,
  parameter int unsigned     CNT_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  truth_table_sweeper_if.slave bus
);

  state_t          state, state_d;
  logic [IDX_W-1:0] row, row_d;
  logic [IDX_W-1:0] ins, ins_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [ROWS-1:0] tbl, tbl_d;
  logic            match_q, match_d;
  logic [ROWS-1:0] mask, mask_d;
  logic            timer_clr_c, timer_en_c, tc_c;

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (timer_clr_c),
    .en  (timer_en_c),
    .tc_c(tc_c)
  );

  // State and all outputs registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      row     <= '0;
      ins     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tbl     <= '0;
      match_q <= 1'b0;
      mask    <= '0;
    end else begin
      state   <= state_d;
      row     <= row_d;
      ins     <= ins_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tbl     <= tbl_d;
      match_q <= match_d;
      mask    <= mask_d;
    end
  end

  always_comb begin
    state_d     = state;
    row_d       = row;
    ins_d       = ins;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tbl_d       = tbl;
    match_d     = match_q;
    mask_d      = mask;
    timer_clr_c = 1'b1;
    timer_en_c  = 1'b0;

    case (state)
      IDLE: begin
        ins_d = '0;
        if (bus.start) begin
          state_d = SETTLE;
          row_d   = '0;
          busy_d  = 1'b1;
          tbl_d   = '0;
          match_d = 1'b0;
          mask_d  = '0;
        end
      end
      SETTLE: begin
        timer_en_c  = 1'b1;
        timer_clr_c = tc_c;
        if (tc_c) state_d = SAMPLE;
      end
      SAMPLE: begin
        tbl_d[row_to_bit(row)] = bus.dut_out;
        if (row == IDX_W'(ROWS - 1)) begin
          state_d = FINISH;
          ins_d   = '0;
          match_d = (tbl_d == EXPECTED);
          mask_d  = tbl_d ^ EXPECTED;
          done_d  = 1'b1;
        end else begin
          state_d = SETTLE;
          row_d   = row + IDX_W'(1);
          ins_d   = row_d;
        end
      end
      FINISH: begin
        state_d = IDLE;
        row_d   = '0;
        ins_d   = '0;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over start and over a pending sample; partial table is kept.
    if (bus.abort && (state != IDLE)) begin
      state_d     = IDLE;
      row_d       = '0;
      ins_d       = '0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      tbl_d       = tbl;
      match_d     = match_q;
      mask_d      = mask;
      timer_clr_c = 1'b1;
      timer_en_c  = 1'b0;
    end
  end

  assign {bus.in1, bus.in2, bus.in3} = ins;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.table_out     = tbl;
  assign bus.match         = match_q;
  assign bus.mismatch_mask = mask;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: vector table, random functions vs. a row-level model,
// and hand-written abort/reset/held-start/short-settle sequences.
module tb_truth_table_sweeper;
  import truth_table_pkg::*;

  localparam logic [7:0] EXP = 8'h28;

  logic       clk;
  logic       rst;
  int         mode;
  logic [7:0] rfunc;
  logic       fa_y, fb_y;
  int         n_checks;
  int         n_fail;

  truth_table_sweeper_if if_a ();
  truth_table_sweeper_if if_b ();

  m0x28 u_fa (.in1(if_a.in1), .in2(if_a.in2), .in3(if_a.in3), .out_c(fa_y));
  m0x28 u_fb (.in1(if_b.in1), .in2(if_b.in2), .in3(if_b.in3), .out_c(fb_y));

  // mode 0: m0x28, mode 1: in1&~in2&~in3, mode 2: arbitrary table rfunc
  assign if_a.dut_out = (mode == 0) ? fa_y :
                        (mode == 1) ? (if_a.in1 & ~if_a.in2 & ~if_a.in3) :
                        rfunc[3'd7 - {if_a.in1, if_a.in2, if_a.in3}];
  assign if_b.dut_out = fb_y;

  truth_table_sweeper #(.SETTLE_CYCLES(4), .EXPECTED(8'h28), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .bus(if_a)
  );
  truth_table_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(8'h28), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst(rst), .bus(if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Function value for row r = {in1,in2,in3} as an integer 0..7.
  function automatic logic fn_val(input int md, input logic [7:0] f, input int r);
    case (md)
      0:       return (r == 2) || (r == 4);
      1:       return (r == 4);
      default: return f[7-r];
    endcase
  endfunction

  function automatic logic [7:0] model_tbl(input int md, input logic [7:0] f);
    logic [7:0] t;
    t = '0;
    for (int r = 0; r < 8; r++) t[7-r] = fn_val(md, f, r);
    return t;
  endfunction

  // One full sweep on DUT A; lat counts edges from the start-accepting edge (=1).
  task automatic sweep_a(output logic [7:0] tbl, output logic m, output logic [7:0] mk,
                         output int lat);
    @(negedge clk); if_a.start = 1'b1;
    @(negedge clk); if_a.start = 1'b0;
    lat = 1;
    while (!if_a.done && lat < 200) begin
      @(negedge clk); lat++;
    end
    tbl = if_a.table_out;
    m   = if_a.match;
    mk  = if_a.mismatch_mask;
    chk("busy_during_done", 8'(if_a.busy), 8'd1);
    @(negedge clk);
    chk("done_one_cycle", 8'(if_a.done), 8'd0);
    chk("busy_after_done", 8'(if_a.busy), 8'd0);
  endtask

  typedef struct {
    int         md;
    logic [7:0] f;
    logic [7:0] tbl;
    logic       m;
    logic [7:0] mask;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [7:0] tbl, mk, et;
    logic       m;
    int         lat, dones;

    n_checks = 0; n_fail = 0;
    mode = 0; rfunc = '0;
    if_a.start = 1'b0; if_a.abort = 1'b0;
    if_b.start = 1'b0; if_b.abort = 1'b0;
    rst = 1'b1;

    vecs[0] = '{0, 8'h00, 8'h28, 1'b1, 8'h00};
    vecs[1] = '{1, 8'h00, 8'h08, 1'b0, 8'h20};
    vecs[2] = '{2, 8'hFF, 8'hFF, 1'b0, 8'hD7};
    vecs[3] = '{2, 8'h00, 8'h00, 1'b0, 8'h28};
    vecs[4] = '{2, 8'h28, 8'h28, 1'b1, 8'h00};
    vecs[5] = '{2, 8'h81, 8'h81, 1'b0, 8'hA9};

    repeat (3) @(negedge clk);
    chk("rst_a_inputs", 8'({if_a.in1, if_a.in2, if_a.in3}), 8'd0);
    chk("rst_a_busy", 8'(if_a.busy), 8'd0);
    chk("rst_a_done", 8'(if_a.done), 8'd0);
    chk("rst_a_table", if_a.table_out, 8'h00);
    chk("rst_a_match", 8'(if_a.match), 8'd0);
    chk("rst_a_mask", if_a.mismatch_mask, 8'h00);
    chk("rst_b_busy", 8'(if_b.busy), 8'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      mode  = vecs[i].md;
      rfunc = vecs[i].f;
      sweep_a(tbl, m, mk, lat);
      chk($sformatf("vec%0d_latency", i), 8'(lat), 8'd41);
      chk($sformatf("vec%0d_table", i), tbl, vecs[i].tbl);
      chk($sformatf("vec%0d_match", i), 8'(m), 8'(vecs[i].m));
      chk($sformatf("vec%0d_mask", i), mk, vecs[i].mask);
    end

    for (int i = 0; i < 8; i++) begin
      mode  = 2;
      rfunc = (i == 3) ? EXP : 8'($urandom_range(0, 255));
      et    = model_tbl(mode, rfunc);
      sweep_a(tbl, m, mk, lat);
      chk($sformatf("rnd%0d_latency", i), 8'(lat), 8'd41);
      chk($sformatf("rnd%0d_table", i), tbl, et);
      chk($sformatf("rnd%0d_match", i), 8'(m), 8'(et == EXP));
      chk($sformatf("rnd%0d_mask", i), mk, et ^ EXP);
    end

    // SETTLE_CYCLES=1: each row held two cycles, rows in ascending order.
    @(negedge clk); if_b.start = 1'b1;
    @(negedge clk); if_b.start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("b_row_at_%0d", k), 8'({if_b.in1, if_b.in2, if_b.in3}), 8'((k - 1) / 2));
      chk($sformatf("b_nodone_at_%0d", k), 8'(if_b.done), 8'd0);
      @(negedge clk);
    end
    chk("b_done_at_17", 8'(if_b.done), 8'd1);
    chk("b_table", if_b.table_out, 8'h28);
    chk("b_match", 8'(if_b.match), 8'd1);

    // Abort right after row 3 has been sampled.
    mode = 0;
    @(negedge clk); if_a.start = 1'b1;
    @(negedge clk); if_a.start = 1'b0;
    lat = 1;
    while (lat < 21) begin @(negedge clk); lat++; end
    if_a.abort = 1'b1;
    @(negedge clk); if_a.abort = 1'b0;
    chk("abort_busy", 8'(if_a.busy), 8'd0);
    chk("abort_inputs", 8'({if_a.in1, if_a.in2, if_a.in3}), 8'd0);
    chk("abort_table", if_a.table_out, 8'h20);
    chk("abort_match", 8'(if_a.match), 8'd0);
    dones = 0;
    repeat (60) begin
      @(negedge clk);
      if (if_a.done) dones++;
    end
    chk("abort_no_done", 8'(dones), 8'd0);
    chk("abort_table_held", if_a.table_out, 8'h20);
    sweep_a(tbl, m, mk, lat);
    chk("post_abort_table", tbl, 8'h28);
    chk("post_abort_match", 8'(m), 8'd1);
    chk("post_abort_mask", mk, 8'h00);

    // Abort while idle changes nothing.
    if_a.abort = 1'b1;
    @(negedge clk); if_a.abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_busy", 8'(if_a.busy), 8'd0);
    chk("idle_abort_table", if_a.table_out, 8'h28);
    chk("idle_abort_match", 8'(if_a.match), 8'd1);

    // start held high: one sweep, then restart from IDLE with a cleared table.
    @(negedge clk); if_a.start = 1'b1;
    dones = 0;
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      if (if_a.done) dones++;
    end
    chk("held_one_done", 8'(dones), 8'd1);
    chk("held_done_at_41", 8'(if_a.done), 8'd1);
    chk("held_table", if_a.table_out, 8'h28);
    @(negedge clk);
    chk("held_idle_busy", 8'(if_a.busy), 8'd0);
    chk("held_idle_done", 8'(if_a.done), 8'd0);
    @(negedge clk);
    chk("held_restart_busy", 8'(if_a.busy), 8'd1);
    chk("held_restart_table", if_a.table_out, 8'h00);
    chk("held_restart_match", 8'(if_a.match), 8'd0);
    if_a.start = 1'b0;
    lat = 0;
    while (!if_a.done && lat < 200) begin @(negedge clk); lat++; end
    chk("held_second_done", 8'(if_a.done), 8'd1);
    chk("held_second_table", if_a.table_out, 8'h28);

    // Async reset between edges during row 5 settle.
    @(negedge clk);
    @(negedge clk); if_a.start = 1'b1;
    @(negedge clk); if_a.start = 1'b0;
    lat = 1;
    while (lat < 27) begin @(negedge clk); lat++; end
    chk("pre_rst_inputs", 8'({if_a.in1, if_a.in2, if_a.in3}), 8'd5);
    #2 rst = 1'b1;
    #1;
    chk("midrst_inputs", 8'({if_a.in1, if_a.in2, if_a.in3}), 8'd0);
    chk("midrst_busy", 8'(if_a.busy), 8'd0);
    chk("midrst_table", if_a.table_out, 8'h00);
    chk("midrst_match", 8'(if_a.match), 8'd0);
    chk("midrst_mask", if_a.mismatch_mask, 8'h00);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 8'(if_a.busy), 8'd0);
    chk("post_rst_done", 8'(if_a.done), 8'd0);
    sweep_a(tbl, m, mk, lat);
    chk("post_rst_latency", 8'(lat), 8'd41);
    chk("post_rst_table", tbl, 8'h28);
    chk("post_rst_match", 8'(m), 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
